input_submit_ctrl: RTL and testbench

//   Sequences user input into the CPU: synchronises and debounces the submit button, captures
//   the switches (case id + 16-bit operand) on each debounced press, and holds the value for the
//   CPU's MMIO read port under a valid/read handshake. Sits between board I/O and main's IO bus.

---
 rtl/input_submit_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_input_submit_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/input_submit_ctrl.sv
// Submit-button sequencer: syncs and debounces the push button, captures the switches on each
// press and holds them for the CPU's MMIO read port. Define INPUT_FIFO_EN for a FIFO_DEPTH queue.
module input_submit_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 24,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        status,
    input  logic        submit,
    input  logic [23:0] switches,
    input  logic        cpu_rd_en,
    input  logic        cpu_clr_ovf,
    output logic [31:0] cpu_rd_data,
    output logic        data_valid,
    output logic        overflow,
    output logic        busy_led
);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_ARMED   = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_btnStable;
    logic               r_btnPrev;
    logic [CNT_W-1:0]   r_dbCnt;
    logic               r_overflow;

    logic               w_press;
    logic               w_empty;
    logic               w_full;
    logic               w_lastEntry;
    logic [23:0]        w_head;
    logic               w_capture;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;

    // A new button level is accepted only after it has held for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_btnStable <= 1'b0;
            r_btnPrev   <= 1'b0;
            r_dbCnt     <= '0;
        end else begin
            r_sync1   <= submit;
            r_sync2   <= r_sync1;
            r_btnPrev <= r_btnStable;
            if (r_sync2 == r_btnStable) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_btnStable <= r_sync2;
                r_dbCnt     <= '0;
            end else begin
                r_dbCnt <= r_dbCnt + 1'b1;
            end
        end
    end

    assign w_press   = r_btnStable & ~r_btnPrev;
    assign w_pop     = cpu_rd_en & ~w_empty & status;
    assign w_capture = w_press & status & (r_state != S_OFF);
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;

`ifdef INPUT_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [23:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [AW:0] w_used;

    // Extra wrap bit on each pointer separates full from empty when the indices coincide.
    assign w_used      = r_wrPtr - r_rdPtr;
    assign w_empty     = (r_wrPtr == r_rdPtr);
    assign w_full      = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_lastEntry = (w_used == (AW+1)'(1));
    assign w_head      = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!status) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr[AW-1:0]] <= switches;
                r_wrPtr                <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end
`else
    logic [23:0] r_hold;
    logic        r_holdValid;

    assign w_empty     = ~r_holdValid;
    assign w_full      = r_holdValid;
    assign w_lastEntry = r_holdValid;
    assign w_head      = r_hold;

    // A push in the same cycle as a pop simply replaces the held value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_holdValid <= 1'b0;
        end else if (!status) begin
            r_hold      <= '0;
            r_holdValid <= 1'b0;
        end else if (w_push) begin
            r_hold      <= switches;
            r_holdValid <= 1'b1;
        end else if (w_pop) begin
            r_holdValid <= 1'b0;
        end
    end
`endif

    // Set beats clear so a drop coinciding with a CPU clear is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (!status) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (cpu_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (!status) begin
            w_nextState = S_OFF;
        end else begin
            case (r_state)
                S_OFF:     w_nextState = S_ARMED;
                S_ARMED:   if (w_push) w_nextState = S_PENDING;
                S_PENDING: if (w_pop && w_lastEntry && !w_push) w_nextState = S_ARMED;
                default:   w_nextState = S_OFF;
            endcase
        end
    end

    always_comb begin
        busy_led    = (r_state == S_PENDING);
        data_valid  = ~w_empty;
        overflow    = r_overflow;
        cpu_rd_data = '0;
        if (!w_empty) begin
            cpu_rd_data = {8'h00, w_head};
        end
    end

endmodule

// File: tb/tb_input_submit_ctrl.sv
// Scoreboarded bench for input_submit_ctrl; expected read data is queued when a read is issued
// and a monitor compares it on the read strobe. Honours INPUT_FIFO_EN like the design.
module tb_input_submit_ctrl;

`ifdef INPUT_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        reset;
    logic        status;
    logic        submit;
    logic [23:0] switches;
    logic        cpu_rd_en;
    logic        cpu_clr_ovf;
    logic [31:0] cpu_rd_data;
    logic        data_valid;
    logic        overflow;
    logic        busy_led;

    int          checks;
    int          errors;
    logic [31:0] sbQueue[$];

    input_submit_ctrl #(
        .DEBOUNCE_CYCLES(20),
        .CNT_W          (24),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .status     (status),
        .submit     (submit),
        .switches   (switches),
        .cpu_rd_en  (cpu_rd_en),
        .cpu_clr_ovf(cpu_clr_ovf),
        .cpu_rd_data(cpu_rd_data),
        .data_valid (data_valid),
        .overflow   (overflow),
        .busy_led   (busy_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean press: held long enough to capture, then released long enough to settle.
    task automatic applyStimulus(input logic [23:0] sw);
        switches = sw;
        submit   = 1'b1;
        waitEdges(25);
        submit   = 1'b0;
        waitEdges(25);
    endtask

    task automatic readPulse(input logic [31:0] expected);
        sbQueue.push_back(expected);
        cpu_rd_en = 1'b1;
        waitEdges(1);
        cpu_rd_en = 1'b0;
        waitEdges(1);
    endtask

    // Monitor: every CPU read strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        if (reset && cpu_rd_en) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got %h expected no read", cpu_rd_data);
            end else begin
                checkOutput("rd_data", cpu_rd_data, sbQueue.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        status      = 1'b0;
        submit      = 1'b0;
        switches    = '0;
        cpu_rd_en   = 1'b0;
        cpu_clr_ovf = 1'b0;
        #1;
        checkOutput("reset_rd_data", cpu_rd_data, 32'h0);
        checkOutput("reset_flags", {29'd0, data_valid, overflow, busy_led}, 32'h0);
        #2;
        reset = 1'b1;
        waitEdges(2);

        $display("[TB] press with status off");
        applyStimulus(24'h000003);
        checkOutput("off_valid", {31'd0, data_valid}, 32'h0);
        checkOutput("off_rd_data", cpu_rd_data, 32'h0);
        checkOutput("off_busy", {31'd0, busy_led}, 32'h0);

        $display("[TB] latency of first capture");
        status = 1'b1;
        waitEdges(2);
        switches = 24'h000003;
        submit   = 1'b1;
        waitEdges(22);
        checkOutput("lat_valid_early", {31'd0, data_valid}, 32'h0);
        waitEdges(1);
        checkOutput("lat_valid_on", {31'd0, data_valid}, 32'h1);
        checkOutput("lat_busy", {31'd0, busy_led}, 32'h1);
        checkOutput("lat_rd_data", cpu_rd_data, 32'h0000_0003);
        waitEdges(5);
        submit = 1'b0;
        waitEdges(25);
        readPulse(32'h0000_0003);
        checkOutput("read_valid_cleared", {31'd0, data_valid}, 32'h0);
        checkOutput("read_armed", {31'd0, busy_led}, 32'h0);

        $display("[TB] bouncing button");
        for (int i = 0; i < 20; i++) begin
            submit = ~submit;
            waitEdges(5);
        end
        submit = 1'b0;
        waitEdges(30);
        checkOutput("bounce_valid", {31'd0, data_valid}, 32'h0);

`ifdef INPUT_FIFO_EN
        $display("[TB] queue fill and drain");
        applyStimulus(24'h010003);
        applyStimulus(24'h01000D);
        applyStimulus(24'h010009);
        applyStimulus(24'h010004);
        checkOutput("fifo_no_ovf_yet", {31'd0, overflow}, 32'h0);
        applyStimulus(24'h010007);
        checkOutput("fifo_overflow", {31'd0, overflow}, 32'h1);
        readPulse(32'h0001_0003);
        readPulse(32'h0001_000D);
        readPulse(32'h0001_0009);
        readPulse(32'h0001_0004);
        checkOutput("fifo_drained", {31'd0, data_valid}, 32'h0);
        readPulse(32'h0000_0000);
        checkOutput("fifo_empty_ovf", {31'd0, overflow}, 32'h1);
        cpu_clr_ovf = 1'b1;
        waitEdges(1);
        cpu_clr_ovf = 1'b0;
        checkOutput("fifo_ovf_clear", {31'd0, overflow}, 32'h0);
`else
        $display("[TB] holding register overflow");
        applyStimulus(24'h00000D);
        checkOutput("hold_no_ovf_yet", {31'd0, overflow}, 32'h0);
        applyStimulus(24'h000009);
        checkOutput("hold_overflow", {31'd0, overflow}, 32'h1);
        checkOutput("hold_rd_data", cpu_rd_data, 32'h0000_000D);
        cpu_clr_ovf = 1'b1;
        waitEdges(1);
        cpu_clr_ovf = 1'b0;
        checkOutput("hold_ovf_clear", {31'd0, overflow}, 32'h0);
        readPulse(32'h0000_000D);
        checkOutput("hold_drained", {31'd0, data_valid}, 32'h0);
        readPulse(32'h0000_0000);
        checkOutput("hold_empty_ovf", {31'd0, overflow}, 32'h0);
`endif

        $display("[TB] status drop flushes pending data");
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(24'h000005);
        end
        checkOutput("flush_pre_valid", {31'd0, data_valid}, 32'h1);
        checkOutput("flush_pre_ovf", {31'd0, overflow}, 32'h1);
        status = 1'b0;
        waitEdges(1);
        checkOutput("flush_valid", {31'd0, data_valid}, 32'h0);
        checkOutput("flush_ovf", {31'd0, overflow}, 32'h0);
        checkOutput("flush_busy", {31'd0, busy_led}, 32'h0);
        checkOutput("flush_rd_data", cpu_rd_data, 32'h0);
        status = 1'b1;
        waitEdges(1);
        checkOutput("rearm_valid", {31'd0, data_valid}, 32'h0);
        checkOutput("rearm_busy", {31'd0, busy_led}, 32'h0);
        applyStimulus(24'h020007);
        checkOutput("rearm_busy_on", {31'd0, busy_led}, 32'h1);
        readPulse(32'h0002_0007);
        checkOutput("rearm_armed", {31'd0, busy_led}, 32'h0);

        waitEdges(2);
        checkOutput("scoreboard_empty", sbQueue.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
